// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle control FSM.
// Encodings for states, opcodes, funct fields, ALU ops and ALU function codes.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_IMMWB  = 4'd10,
        S_JUMP   = 4'd11,
        S_LIEX   = 4'd12,
        S_HALT   = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_LI    = 6'b010001;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_CMP   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_LI  = 4'b0100;
    localparam logic [3:0] ALU_CMP = 4'b0110;
    localparam logic [3:0] ALU_SUB = 4'b1010;
    localparam logic [3:0] ALU_SLT = 4'b1011;

    function automatic logic funct_legal(input logic [5:0] f);
        return (f == F_ADD) || (f == F_SUB) || (f == F_AND) ||
               (f == F_OR)  || (f == F_SLT);
    endfunction

endpackage

// File: rtl/mc_alu_decode.sv
// ALU function decoder: {aluop, op, funct} -> 4-bit alucontrol.
module mc_alu_decode
    import mc_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output logic [3:0] alucontrol
);

    always_comb begin
        alucontrol = ALU_AND;
        case (aluop)
            ALUOP_ADD:   alucontrol = (op == OP_LI) ? ALU_LI : ALU_ADD;
            ALUOP_CMP:   alucontrol = ALU_CMP;
            ALUOP_FUNCT: begin
                case (funct)
                    F_ADD:   alucontrol = ALU_ADD;
                    F_SUB:   alucontrol = ALU_SUB;
                    F_AND:   alucontrol = ALU_AND;
                    F_OR:    alucontrol = ALU_OR;
                    F_SLT:   alucontrol = ALU_SLT;
                    default: alucontrol = ALU_AND;
                endcase
            end
            default:     alucontrol = ALU_AND;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle control FSM with memory wait states and a stall watchdog.
// Optional MC_ILLEGAL_TRAP_EN: unknown op/funct halts and raises illegal_op.
module mc_controller
    import mc_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic       pcen,
    output logic [3:0] alucontrol,
    output logic       instr_done,
    output logic [3:0] state,
    output logic       mem_timeout
`ifdef MC_ILLEGAL_TRAP_EN
    ,
    output logic       illegal_op
`endif
);

    localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] STALL_MAX = CW'(MEM_TIMEOUT);

    state_t        state_q, state_d, st;
    logic [CW-1:0] stall_q, stall_d;
    logic          timeout_q, timeout_d;
    logic          pcwrite, branch, waiting;
    logic [1:0]    aluop;

    // Under reset the outputs decode as FETCH; strobes are masked below.
    assign st = reset ? S_FETCH : state_q;

    always_comb begin
        state_d    = st;
        iord       = 1'b0;
        memwrite   = 1'b0;
        irwrite    = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        regwrite   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        aluop      = ALUOP_ADD;
        instr_done = 1'b0;
        case (st)
            S_FETCH: begin
                alusrcb = 2'b01;
                if (mem_ready) begin
                    irwrite = 1'b1;
                    pcwrite = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                alusrcb = 2'b11;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    OP_LI:        state_d = S_LIEX;
`ifdef MC_ILLEGAL_TRAP_EN
                    default:      state_d = S_HALT;
`else
                    default:      state_d = S_FETCH;
`endif
                endcase
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                iord = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                memtoreg   = 1'b1;
                regwrite   = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
                if (mem_ready) begin
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end
            end
            S_EXEC: begin
                alusrca = 1'b1;
                aluop   = ALUOP_FUNCT;
                state_d = S_ALUWB;
`ifdef MC_ILLEGAL_TRAP_EN
                if (!funct_legal(funct)) state_d = S_HALT;
`endif
            end
            S_ALUWB: begin
                regdst     = 1'b1;
                regwrite   = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                alusrca    = 1'b1;
                aluop      = ALUOP_CMP;
                pcsrc      = 2'b01;
                branch     = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = S_IMMWB;
            end
            S_LIEX: begin
                alusrcb = 2'b10;
                state_d = S_IMMWB;
            end
            S_IMMWB: begin
                regwrite   = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_JUMP: begin
                pcsrc      = 2'b10;
                pcwrite    = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
        pcen = pcwrite | (branch & zero);
        if (reset) begin
            pcen       = 1'b0;
            irwrite    = 1'b0;
            regwrite   = 1'b0;
            memwrite   = 1'b0;
            instr_done = 1'b0;
        end
    end

    assign waiting = !mem_ready &&
                     (st == S_FETCH || st == S_MEMRD || st == S_MEMWR);

    always_comb begin
        stall_d   = '0;
        timeout_d = timeout_q;
        if (MEM_TIMEOUT != 0 && waiting) begin
            stall_d = (stall_q == STALL_MAX) ? stall_q : stall_q + 1'b1;
            if (stall_d == STALL_MAX) timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            stall_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            stall_q   <= stall_d;
            timeout_q <= timeout_d;
        end
    end

    mc_alu_decode u_alu_decode (
        .aluop      (aluop),
        .op         (op),
        .funct      (funct),
        .alucontrol (alucontrol)
    );

    assign state       = state_q;
    assign mem_timeout = timeout_q;
`ifdef MC_ILLEGAL_TRAP_EN
    assign illegal_op  = (st == S_HALT);
`endif

endmodule

// File: tb/tb_mc_controller.sv
// Directed self-checking bench for mc_controller (MEM_TIMEOUT=4).
module tb_mc_controller;

    logic       clk, reset, zero, mem_ready;
    logic [5:0] op, funct;
    logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite;
    logic       alusrca, pcen, instr_done, mem_timeout;
    logic [1:0] alusrcb, pcsrc;
    logic [3:0] alucontrol, state;
`ifdef MC_ILLEGAL_TRAP_EN
    logic       illegal_op;
`endif

    int npass = 0;
    int ntotal = 0;

    mc_controller #(.MEM_TIMEOUT(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .op          (op),
        .funct       (funct),
        .zero        (zero),
        .mem_ready   (mem_ready),
        .iord        (iord),
        .memwrite    (memwrite),
        .irwrite     (irwrite),
        .regdst      (regdst),
        .memtoreg    (memtoreg),
        .regwrite    (regwrite),
        .alusrca     (alusrca),
        .alusrcb     (alusrcb),
        .pcsrc       (pcsrc),
        .pcen        (pcen),
        .alucontrol  (alucontrol),
        .instr_done  (instr_done),
        .state       (state),
        .mem_timeout (mem_timeout)
`ifdef MC_ILLEGAL_TRAP_EN
        ,
        .illegal_op  (illegal_op)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        reset = 1'b1; op = 6'b100011; funct = 6'd0;
        zero = 1'b0; mem_ready = 1'b1;
        settle();
        chk("rst_pcen", pcen, 0);
        chk("rst_irwrite", irwrite, 0);
        chk("rst_alusrcb", alusrcb, 2'b01);
        step(); step();
        chk("rst_state", state, 0);
        chk("rst_timeout", mem_timeout, 0);
        reset = 1'b0;

        // lw, 5 cycles
        settle();
        chk("lw_c1_state", state, 0);
        chk("lw_c1_irwrite", irwrite, 1);
        chk("lw_c1_pcen", pcen, 1);
        chk("lw_c1_aluc", alucontrol, 4'b0010);
        step(); chk("lw_c2_state", state, 1);
        chk("lw_c2_alusrcb", alusrcb, 2'b11);
        step(); chk("lw_c3_state", state, 2);
        chk("lw_c3_alusrcb", alusrcb, 2'b10);
        step(); chk("lw_c4_state", state, 3);
        chk("lw_c4_iord", iord, 1);
        step(); chk("lw_c5_state", state, 4);
        chk("lw_c5_regwrite", regwrite, 1);
        chk("lw_c5_memtoreg", memtoreg, 1);
        chk("lw_c5_done", instr_done, 1);
        step(); chk("lw_end_state", state, 0);

        // R-type slt, 4 cycles
        op = 6'b000000; funct = 6'b101010;
        step(); step();
        chk("r_exec_state", state, 6);
        chk("r_exec_aluc", alucontrol, 4'b1011);
        chk("r_exec_alusrca", alusrca, 1);
        step(); chk("r_wb_state", state, 7);
        chk("r_wb_regdst", regdst, 1);
        chk("r_wb_done", instr_done, 1);
        step(); chk("r_end_state", state, 0);

        // beq taken / not taken, 3 cycles each
        op = 6'b000100; zero = 1'b1;
        step(); step();
        chk("beq1_state", state, 8);
        chk("beq1_pcen", pcen, 1);
        chk("beq1_pcsrc", pcsrc, 2'b01);
        chk("beq1_aluc", alucontrol, 4'b0110);
        step(); chk("beq1_end", state, 0);
        zero = 1'b0;
        step(); step();
        chk("beq0_pcen", pcen, 0);
        chk("beq0_done", instr_done, 1);
        step(); chk("beq0_end", state, 0);

        // sw with 3 wait cycles in MEMWR
        op = 6'b101011;
        step(); step(); step();
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("sw_wait_state", state, 5);
            chk("sw_wait_memwrite", memwrite, 1);
            chk("sw_wait_done", instr_done, 0);
            step();
        end
        mem_ready = 1'b1;
        settle();
        chk("sw_last_memwrite", memwrite, 1);
        chk("sw_last_done", instr_done, 1);
        chk("sw_timeout", mem_timeout, 0);
        step(); chk("sw_end", state, 0);

        // j, 3 cycles
        op = 6'b000010;
        step(); step();
        chk("j_state", state, 11);
        chk("j_pcsrc", pcsrc, 2'b10);
        chk("j_pcen", pcen, 1);
        step(); chk("j_end", state, 0);

        // li, 4 cycles
        op = 6'b010001;
        step(); step();
        chk("li_state", state, 12);
        chk("li_aluc", alucontrol, 4'b0100);
        chk("li_alusrca", alusrca, 0);
        step(); chk("li_wb_state", state, 10);
        chk("li_wb_regwrite", regwrite, 1);
        chk("li_wb_regdst", regdst, 0);
        step(); chk("li_end", state, 0);

        // addi, 4 cycles
        op = 6'b001000;
        step(); step();
        chk("addi_state", state, 9);
        chk("addi_alusrca", alusrca, 1);
        step(); chk("addi_wb_state", state, 10);
        step(); chk("addi_end", state, 0);

        // unknown opcode
        op = 6'b111111;
        step();
        chk("ill_decode", state, 1);
        chk("ill_decode_rw", regwrite, 0);
        chk("ill_decode_done", instr_done, 0);
        step();
`ifdef MC_ILLEGAL_TRAP_EN
        chk("ill_halt", state, 13);
        chk("ill_flag", illegal_op, 1);
        step();
        chk("ill_stay", state, 13);
        chk("ill_flag2", illegal_op, 1);
        chk("ill_rw", regwrite, 0);
        reset = 1'b1; step(); reset = 1'b0;
        settle();
        chk("ill_cleared", illegal_op, 0);
`else
        chk("ill_fetch", state, 0);
        chk("ill_rw", regwrite, 0);
`endif

        // reset mid-lw aborts without strobes
        op = 6'b100011;
        step(); step(); step();
        chk("abort_pre", state, 3);
        reset = 1'b1;
        settle();
        chk("abort_iord", iord, 0);
        chk("abort_rw", regwrite, 0);
        chk("abort_irw", irwrite, 0);
        step(); reset = 1'b0;
        settle();
        chk("abort_state", state, 0);

        // watchdog: 6 stalled FETCH cycles
        mem_ready = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            settle();
            chk("wd_timeout", mem_timeout, (k >= 5) ? 1 : 0);
            chk("wd_irwrite", irwrite, 0);
            step();
        end
        mem_ready = 1'b1;
        settle();
        chk("wd_sticky", mem_timeout, 1);
        chk("wd_irw", irwrite, 1);
        step();
        chk("wd_decode", state, 1);
        chk("wd_sticky2", mem_timeout, 1);
        reset = 1'b1; step(); reset = 1'b0;
        chk("wd_reset", mem_timeout, 0);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
